// File: rtl/nec_frame_assembler.sv
// ---------------------------------------------------------------------------
// nec_frame_assembler
//   Last stage of the IR receive path. It takes the data/shift/clear_n/send
//   strobes from the NEC decoder FSM and shifts the 32 frame bits in, LSB
//   first. On send it validates the frame: the bit count must be exact, the
//   command byte must match its inverse, and with STRICT_ADDR=1 the address
//   byte must also match its inverse. A good frame is handed to the consumer
//   through a valid/ready handshake.
//
//   Parameters
//     FRAME_BITS   bits per frame (shift register width, required count)
//     STRICT_ADDR  0: extended NEC, 16-bit address, no address check
//                  1: standard NEC, addr = {8'h00, byte0}, byte1 == ~byte0
//
//   Ports
//     clk      in   system clock, all logic on posedge
//     reset_n  in   asynchronous active-low reset
//     data     in   decoded bit value, qualified by shift
//     shift    in   1-cycle strobe: shift data in
//     clear_n  in   active-low: discard the partial frame
//     send     in   1-cycle strobe: frame complete, validate it
//     ready    in   consumer accepts addr/cmd when valid && ready
//     addr     out  frame address, held while valid
//     cmd      out  frame command, held while valid
//     valid    out  addr/cmd hold an unconsumed good frame
//     err      out  1-cycle pulse: frame rejected
//     overrun  out  1-cycle pulse: good frame dropped, slot still occupied
// ---------------------------------------------------------------------------
module nec_frame_assembler #(
  parameter int unsigned FRAME_BITS  = 32,
  parameter bit          STRICT_ADDR = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data,
  input  logic        shift,
  input  logic        clear_n,
  input  logic        send,
  input  logic        ready,
  output logic [15:0] addr,
  output logic [7:0]  cmd,
  output logic        valid,
  output logic        err,
  output logic        overrun
);

  typedef enum logic {COLLECT, CHECK} state_t;

  localparam logic [5:0] CNT_FULL = 6'(FRAME_BITS);
  localparam logic [5:0] CNT_MAX  = 6'h3F;

  state_t                state;
  logic [FRAME_BITS-1:0] sr;
  logic [5:0]            bit_cnt;
  logic                  good;

  always_comb begin
    good = (bit_cnt == CNT_FULL) && (sr[31:24] == ~sr[23:16]);
    if (STRICT_ADDR && (sr[15:8] != ~sr[7:0]))
      good = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= COLLECT;
      sr      <= '0;
      bit_cnt <= '0;
      addr    <= '0;
      cmd     <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      err     <= 1'b0;
      overrun <= 1'b0;
      // Consumption first; a frame loaded by CHECK below overrides it.
      if (valid && ready)
        valid <= 1'b0;

      case (state)
        COLLECT: begin
          if (!clear_n) begin
            sr      <= '0;
            bit_cnt <= '0;
          end else if (shift) begin
            sr <= {data, sr[FRAME_BITS-1:1]};
            // Saturate so an over-long burst can never alias back to 32.
            if (bit_cnt != CNT_MAX)
              bit_cnt <= bit_cnt + 6'd1;
          end
          if (send)
            state <= CHECK;
        end

        CHECK: begin
          if (good) begin
            if (!valid || ready) begin
              addr  <= STRICT_ADDR ? {8'h00, sr[7:0]} : sr[15:0];
              cmd   <= sr[23:16];
              valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            err <= 1'b1;
          end
          sr      <= '0;
          bit_cnt <= '0;
          state   <= COLLECT;
        end

        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_nec_frame_assembler.sv
// ---------------------------------------------------------------------------
// tb_nec_frame_assembler
//   Directed bench for nec_frame_assembler. Two instances share all inputs:
//   u_ext (STRICT_ADDR=0) and u_std (STRICT_ADDR=1). Inputs change on the
//   falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_nec_frame_assembler;

  logic        clk;
  logic        reset_n;
  logic        data;
  logic        shift;
  logic        clear_n;
  logic        send;
  logic        ready;
  logic [15:0] addr_e, addr_s;
  logic [7:0]  cmd_e, cmd_s;
  logic        valid_e, valid_s;
  logic        err_e, err_s;
  logic        ovr_e, ovr_s;

  int checks   = 0;
  int failures = 0;

  nec_frame_assembler #(.FRAME_BITS(32), .STRICT_ADDR(1'b0)) u_ext (
    .clk(clk), .reset_n(reset_n), .data(data), .shift(shift),
    .clear_n(clear_n), .send(send), .ready(ready),
    .addr(addr_e), .cmd(cmd_e), .valid(valid_e), .err(err_e), .overrun(ovr_e)
  );

  nec_frame_assembler #(.FRAME_BITS(32), .STRICT_ADDR(1'b1)) u_std (
    .clk(clk), .reset_n(reset_n), .data(data), .shift(shift),
    .clear_n(clear_n), .send(send), .ready(ready),
    .addr(addr_s), .cmd(cmd_s), .valid(valid_s), .err(err_s), .overrun(ovr_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shift the low n bits of w, LSB first; leaves shift=0 on return.
  task automatic shift_bits(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      shift = 1'b1;
      data  = w[i];
    end
    @(negedge clk);
    shift = 1'b0;
    data  = 1'b0;
  endtask

  // Pulse send; returns at the sample point where CHECK results are visible.
  task automatic send_and_wait();
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    @(negedge clk);
  endtask

  task automatic consume();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    data    = 1'b0;
    shift   = 1'b0;
    clear_n = 1'b1;
    send    = 1'b0;
    ready   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, valid_e}, 32'd0);
    check("rst_addr",  {16'd0, addr_e},  32'd0);
    check("rst_cmd",   {24'd0, cmd_e},   32'd0);
    check("rst_err",   {31'd0, err_e},   32'd0);
    check("rst_ovr",   {31'd0, ovr_e},   32'd0);
    reset_n = 1'b1;

    // 1: good frame, both address modes
    shift_bits(64'hBA45FF00, 32);
    send_and_wait();
    check("t1_valid_e", {31'd0, valid_e}, 32'd1);
    check("t1_addr_e",  {16'd0, addr_e},  32'hFF00);
    check("t1_cmd_e",   {24'd0, cmd_e},   32'h45);
    check("t1_err_e",   {31'd0, err_e},   32'd0);
    check("t1_valid_s", {31'd0, valid_s}, 32'd1);
    check("t1_addr_s",  {16'd0, addr_s},  32'h0000);
    check("t1_cmd_s",   {24'd0, cmd_s},   32'h45);
    consume();
    check("t1_consumed", {31'd0, valid_e}, 32'd0);
    check("t1_hold_cmd", {24'd0, cmd_e},   32'h45);

    // 2: bad command inverse
    shift_bits(64'hBB45FF00, 32);
    send_and_wait();
    check("t2_err_e",   {31'd0, err_e},   32'd1);
    check("t2_err_s",   {31'd0, err_s},   32'd1);
    check("t2_valid",   {31'd0, valid_e}, 32'd0);
    @(negedge clk);
    check("t2_err_end", {31'd0, err_e},   32'd0);

    // 3: short, long and wrap-prone bit counts
    shift_bits(64'hBA45FF00, 31);
    send_and_wait();
    check("t3_short_err",   {31'd0, err_e},   32'd1);
    check("t3_short_valid", {31'd0, valid_e}, 32'd0);
    shift_bits(64'h00_BA45FF00, 40);
    send_and_wait();
    check("t3_long_err",    {31'd0, err_e},   32'd1);
    // 96 shifts: a wrapping 6-bit counter would read 32 and accept this
    shift_bits(64'h0, 64);
    shift_bits(64'hBA45FF00, 32);
    send_and_wait();
    check("t3_sat_err",     {31'd0, err_e},   32'd1);
    check("t3_sat_valid",   {31'd0, valid_e}, 32'd0);

    // 4: clear_n discards partial frames, with and without a concurrent shift
    shift_bits(64'h3FF, 10);
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    shift_bits(64'h3FF, 10);
    clear_n = 1'b0;
    shift   = 1'b1;
    data    = 1'b1;
    @(negedge clk);
    clear_n = 1'b1;
    shift   = 1'b0;
    data    = 1'b0;
    shift_bits(64'hE71800FF, 32);
    send_and_wait();
    check("t4_valid", {31'd0, valid_e}, 32'd1);
    check("t4_err",   {31'd0, err_e},   32'd0);
    check("t4_addr_e", {16'd0, addr_e}, 32'h00FF);
    check("t4_addr_s", {16'd0, addr_s}, 32'h00FF);
    check("t4_cmd",   {24'd0, cmd_e},   32'h18);
    consume();

    // 5: overrun, consumption, and load-while-consumed
    shift_bits(64'hBA45FF00, 32);
    send_and_wait();
    check("t5_first_valid", {31'd0, valid_e}, 32'd1);
    shift_bits(64'hB946FF00, 32);
    send_and_wait();
    check("t5_ovr",       {31'd0, ovr_e},   32'd1);
    check("t5_ovr_s",     {31'd0, ovr_s},   32'd1);
    check("t5_ovr_cmd",   {24'd0, cmd_e},   32'h45);
    check("t5_ovr_valid", {31'd0, valid_e}, 32'd1);
    check("t5_ovr_err",   {31'd0, err_e},   32'd0);
    @(negedge clk);
    check("t5_ovr_end",   {31'd0, ovr_e},   32'd0);
    consume();
    check("t5_drop",      {31'd0, valid_e}, 32'd0);
    shift_bits(64'hBA45FF00, 32);
    send_and_wait();
    check("t5_reload",    {31'd0, valid_e}, 32'd1);
    shift_bits(64'hE71800FF, 32);
    send = 1'b1;
    @(negedge clk);
    send  = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    check("t5_swap_valid", {31'd0, valid_e}, 32'd1);
    check("t5_swap_cmd",   {24'd0, cmd_e},   32'h18);
    check("t5_swap_ovr",   {31'd0, ovr_e},   32'd0);
    @(negedge clk);
    ready = 1'b0;
    check("t5_swap_drop",  {31'd0, valid_e}, 32'd0);

    // 6: asynchronous reset mid-frame with a pending valid
    shift_bits(64'hBA45FF00, 32);
    send_and_wait();
    check("t6_pre_valid", {31'd0, valid_e}, 32'd1);
    shift_bits(64'hFFFF, 16);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, valid_e}, 32'd0);
    check("t6_rst_addr",  {16'd0, addr_e},  32'd0);
    check("t6_rst_cmd",   {24'd0, cmd_e},   32'd0);
    check("t6_rst_err",   {31'd0, err_e},   32'd0);
    check("t6_rst_ovr",   {31'd0, ovr_e},   32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    shift_bits(64'hE71800FF, 32);
    send_and_wait();
    check("t6_after_valid", {31'd0, valid_e}, 32'd1);
    check("t6_after_addr",  {16'd0, addr_e},  32'h00FF);
    check("t6_after_cmd",   {24'd0, cmd_e},   32'h18);
    check("t6_after_err",   {31'd0, err_e},   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
